// File: rtl/ps2_pkg.sv
// Types and constants shared by the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_scan_rx_if.sv
// Key-event handshake between the PS/2 receiver and its consumer.
interface ps2_scan_rx_if;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic       ev_valid;
  logic       ev_ready;

  modport master (output ev_code, ev_ext, ev_brk, ev_valid, input ev_ready);
  modport slave  (input ev_code, ev_ext, ev_brk, ev_valid, output ev_ready);
endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  // extra pointer MSB separates full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid = !empty;
  assign pop   = valid && ready;
  assign wr_en = push && (!full || pop);
  assign head  = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: filters the raw lines, deframes bytes and folds
// E0/F0 prefixes into {ext, brk, code} events queued for the consumer.
//
// state  | meaning
// IDLE   | waiting for a start bit (kdata=0 on a kclk fall)
// DATA   | shifting 8 data bits, LSB first
// PARITY | checking odd parity over data + parity bit
// STOP   | sampling stop bit, then byte_done or an error pulse
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          kclk,
  input  logic          kdata,
  ps2_scan_rx_if.master ev,
  output logic          parity_err,
  output logic          frame_err,
  output logic          overflow
);
  localparam longint         TO_CYC  = longint'(TIMEOUT_US) * longint'(CLK_HZ) / 1_000_000;
  localparam int             TW      = $clog2(TO_CYC);
  localparam int             FW      = $clog2(FILTER_LEN);
  localparam logic [TW-1:0]  TO_LAST = TW'(TO_CYC - 1);
  localparam logic [FW-1:0]  F_LAST  = FW'(FILTER_LEN - 1);

  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [FW-1:0] fcnt [2];
  logic          kclk_q;
  logic          fall;
  logic          kd;

  ps2_state_t    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] to_cnt;
  logic          byte_done;

  logic          ext_pend;
  logic          brk_pend;
  logic          push;
  ps2_evt_t      push_evt;
  ps2_evt_t      head;

  // bit 0 = kclk, bit 1 = kdata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
      kclk_q  <= 1'b1;
    end else begin
      sync1  <= {kdata, kclk};
      sync2  <= sync1;
      kclk_q <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == F_LAST) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign fall = kclk_q && !filt[0];
  assign kd   = filt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      to_cnt     <= '0;
      byte_done  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_done  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      to_cnt     <= (state == IDLE || fall) ? '0 : to_cnt + TW'(1);
      if (state != IDLE && !fall && to_cnt == TO_LAST) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        to_cnt    <= '0;
      end else if (fall) begin
        unique case (state)
          IDLE: begin
            if (!kd) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {kd, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{shreg, kd};
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!kd)          frame_err  <= 1'b1;
            else if (!par_ok) parity_err <= 1'b1;
            else              byte_done  <= 1'b1;
          end
        endcase
      end
    end
  end

  // shreg holds the received byte until the next frame's first data bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (parity_err || frame_err) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_done) begin
      if (shreg == PS2_EXT) begin
        ext_pend <= 1'b1;
      end else if (shreg == PS2_BRK) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  assign push     = byte_done && (shreg != PS2_EXT) && (shreg != PS2_BRK);
  assign push_evt = {ext_pend, brk_pend, shreg};

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_evt_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_evt),
    .ready     (ev.ev_ready),
    .head      (head),
    .valid     (ev.ev_valid),
    .overflow  (overflow)
  );

  assign ev.ev_code = head.code;
  assign ev.ev_ext  = head.ext;
  assign ev.ev_brk  = head.brk;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: drives PS/2 frames and compares popped events with a
// queue-based model of the prefix/event rules.
module tb_ps2_scan_rx;
  import ps2_pkg::*;

  localparam int CLK_HZ     = 1_000_000;
  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT_US = 200;
  localparam int FIFO_DEPTH = 4;
  localparam int TO_CYC     = TIMEOUT_US * (CLK_HZ / 1_000_000);
  localparam int HALF       = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic kclk  = 1'b1;
  logic kdata = 1'b1;
  logic parity_err, frame_err, overflow;

  ps2_scan_rx_if ev();

  ps2_scan_rx #(
    .CLK_HZ     (CLK_HZ),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_US (TIMEOUT_US),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kclk       (kclk),
    .kdata      (kdata),
    .ev         (ev),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;  // 0 hold off, 1 always ready, 2 random
  int pe_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int got_rd = 0;
  int exp_ovf = 0;
  bit m_ext = 0, m_brk = 0;
  ps2_evt_t exp_q[$];
  ps2_evt_t got_q[$];

  // consumer: picks ev_ready, logs every accepted event and counts pulses
  always @(negedge clk) begin
    ev.ev_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1);
    if (rst_n) begin
      if (ev.ev_valid && ev.ev_ready) got_q.push_back({ev.ev_ext, ev.ev_brk, ev.ev_code});
      if (parity_err) pe_cnt++;
      if (frame_err)  fe_cnt++;
      if (overflow)   ov_cnt++;
    end
  end

  function automatic logic [7:0] rand_code();
    logic [7:0] c;
    do c = 8'($urandom); while (c == PS2_EXT || c == PS2_BRK);
    return c;
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit err);
    if (err) begin
      m_ext = 0; m_brk = 0;
    end else if (b == PS2_EXT) begin
      m_ext = 1;
    end else if (b == PS2_BRK) begin
      m_brk = 1;
    end else begin
      if (ready_mode == 0 && exp_q.size() == FIFO_DEPTH) exp_ovf++;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    kdata = b;
    repeat (HALF / 2) @(negedge clk);
    if (glitch) begin
      kclk = 0;
      repeat (FILTER_LEN - 1) @(negedge clk);
      kclk = 1;
    end
    repeat (HALF / 2) @(negedge clk);
    kclk = 0;
    repeat (HALF) @(negedge clk);
    kclk = 1;
  endtask

  // lat = negedges from the stop-bit kclk fall until ev_valid is seen high
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int gbit, output int lat);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0, gbit == 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], gbit == i + 1);
    send_bit(par, gbit == 9);
    kdata = ~bad_stop;
    repeat (HALF) @(negedge clk);
    kclk = 0;
    model_frame(b, bad_par || bad_stop);
    lat = -1;
    for (int c = 1; c <= HALF; c++) begin
      @(negedge clk);
      if (lat < 0 && ev.ev_valid === 1'b1) lat = c;
    end
    kclk = 1;
    kdata = 1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic drain();
    ready_mode = 1;
    for (int c = 0; c < 300 && got_q.size() - got_rd < exp_q.size(); c++) @(negedge clk);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    checks++; if (ev.ev_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", ev.ev_valid); end
    checks++; if (ev.ev_code !== 8'h00) begin failures++; $display("FAIL reset_code: got %h want 00", ev.ev_code); end
    checks++; if (ev.ev_ext !== 1'b0) begin failures++; $display("FAIL reset_ext: got %b want 0", ev.ev_ext); end
    checks++; if (ev.ev_brk !== 1'b0) begin failures++; $display("FAIL reset_brk: got %b want 0", ev.ev_brk); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    repeat (4) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    checks++; if (ev.ev_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got %b want 0", ev.ev_valid); end
  endtask

  task automatic test_latency();
    int lat;
    ready_mode = 0;
    send_frame(8'h1C, 0, 0, -1, lat);
    // 2 sync flops + FILTER_LEN filter cycles, then byte_done, then push
    checks++; if (lat !== 2 + FILTER_LEN + 2) begin failures++; $display("FAIL latency: got %0d want %0d", lat, 2 + FILTER_LEN + 2); end
    checks++; if ({ev.ev_ext, ev.ev_brk, ev.ev_code} !== 10'h01C) begin failures++; $display("FAIL latency_head: got %h want 01c", {ev.ev_ext, ev.ev_brk, ev.ev_code}); end
    drain();
    checks++; if (got_q.size() - got_rd != exp_q.size()) begin failures++; $display("FAIL latency_count: got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && got_rd + i < got_q.size(); i++) begin
      checks++; if (got_q[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL latency_evt%0d: got %h want %h", i, got_q[got_rd + i], exp_q[i]); end
    end
    got_rd = got_q.size(); exp_q.delete();
  endtask

  task automatic test_prefix();
    int lat;
    ready_mode = 2;
    send_frame(PS2_EXT, 0, 0, -1, lat);
    send_frame(PS2_BRK, 0, 0, -1, lat);
    send_frame(8'h75, 0, 0, -1, lat);
    send_frame(PS2_EXT, 0, 0, -1, lat);
    send_frame(rand_code(), 0, 0, -1, lat);
    send_frame(PS2_BRK, 0, 0, -1, lat);
    send_frame(rand_code(), 0, 0, -1, lat);
    drain();
    checks++; if (got_q.size() - got_rd != exp_q.size()) begin failures++; $display("FAIL prefix_count: got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && got_rd + i < got_q.size(); i++) begin
      checks++; if (got_q[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL prefix_evt%0d: got %h want %h", i, got_q[got_rd + i], exp_q[i]); end
    end
    got_rd = got_q.size(); exp_q.delete();
  endtask

  task automatic test_parity();
    int lat, pe0;
    ready_mode = 2;
    pe0 = pe_cnt;
    send_frame(PS2_EXT, 0, 0, -1, lat);
    send_frame(8'h1C, 1, 0, -1, lat);
    send_frame(PS2_BRK, 0, 0, -1, lat);
    send_frame(8'h1C, 0, 0, -1, lat);
    checks++; if (pe_cnt - pe0 != 1) begin failures++; $display("FAIL parity_pulses: got %0d want 1", pe_cnt - pe0); end
    drain();
    checks++; if (got_q.size() - got_rd != exp_q.size()) begin failures++; $display("FAIL parity_count: got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && got_rd + i < got_q.size(); i++) begin
      checks++; if (got_q[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL parity_evt%0d: got %h want %h", i, got_q[got_rd + i], exp_q[i]); end
    end
    got_rd = got_q.size(); exp_q.delete();
  endtask

  task automatic test_timeout();
    int lat, fe0, pe0;
    ready_mode = 2;
    send_frame(PS2_EXT, 0, 0, -1, lat);
    fe0 = fe_cnt; pe0 = pe_cnt;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 0);
    m_ext = 0; m_brk = 0;
    repeat (TO_CYC + 60) @(negedge clk);
    checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL timeout_pulses: got %0d want 1", fe_cnt - fe0); end
    checks++; if (pe_cnt - pe0 != 0) begin failures++; $display("FAIL timeout_perr: got %0d want 0", pe_cnt - pe0); end
    send_frame(rand_code(), 0, 0, -1, lat);
    drain();
    checks++; if (got_q.size() - got_rd != exp_q.size()) begin failures++; $display("FAIL timeout_count: got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && got_rd + i < got_q.size(); i++) begin
      checks++; if (got_q[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL timeout_evt%0d: got %h want %h", i, got_q[got_rd + i], exp_q[i]); end
    end
    got_rd = got_q.size(); exp_q.delete();
  endtask

  task automatic test_overflow();
    int lat, ov0;
    ready_mode = 0;
    ov0 = ov_cnt;
    exp_ovf = 0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) send_frame(rand_code(), 0, 0, -1, lat);
    checks++; if (ov_cnt - ov0 != exp_ovf) begin failures++; $display("FAIL overflow_pulses: got %0d want %0d", ov_cnt - ov0, exp_ovf); end
    checks++; if (ev.ev_valid !== 1'b1) begin failures++; $display("FAIL overflow_valid: got %b want 1", ev.ev_valid); end
    drain();
    checks++; if (got_q.size() - got_rd != exp_q.size()) begin failures++; $display("FAIL overflow_count: got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && got_rd + i < got_q.size(); i++) begin
      checks++; if (got_q[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL overflow_evt%0d: got %h want %h", i, got_q[got_rd + i], exp_q[i]); end
    end
    got_rd = got_q.size(); exp_q.delete();
  endtask

  task automatic test_glitch();
    int lat;
    ready_mode = 2;
    for (int n = 0; n < 3; n++) send_frame(rand_code(), 0, 0, $urandom_range(1, 9), lat);
    drain();
    checks++; if (got_q.size() - got_rd != exp_q.size()) begin failures++; $display("FAIL glitch_count: got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && got_rd + i < got_q.size(); i++) begin
      checks++; if (got_q[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL glitch_evt%0d: got %h want %h", i, got_q[got_rd + i], exp_q[i]); end
    end
    got_rd = got_q.size(); exp_q.delete();
  endtask

  task automatic test_random();
    int lat, pe0, fe0, exp_pe, exp_fe, sel, err;
    logic [7:0] c;
    ready_mode = 2;
    pe0 = pe_cnt; fe0 = fe_cnt; exp_pe = 0; exp_fe = 0;
    for (int n = 0; n < 12; n++) begin
      sel = $urandom_range(0, 9);
      c = (sel == 0) ? PS2_EXT : (sel == 1) ? PS2_BRK : rand_code();
      err = $urandom_range(0, 9);
      if (err == 0) exp_pe++;
      if (err == 1) exp_fe++;
      send_frame(c, err == 0, err == 1, -1, lat);
    end
    drain();
    checks++; if (pe_cnt - pe0 != exp_pe) begin failures++; $display("FAIL random_perr: got %0d want %0d", pe_cnt - pe0, exp_pe); end
    checks++; if (fe_cnt - fe0 != exp_fe) begin failures++; $display("FAIL random_ferr: got %0d want %0d", fe_cnt - fe0, exp_fe); end
    checks++; if (got_q.size() - got_rd != exp_q.size()) begin failures++; $display("FAIL random_count: got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && got_rd + i < got_q.size(); i++) begin
      checks++; if (got_q[got_rd + i] !== exp_q[i]) begin failures++; $display("FAIL random_evt%0d: got %h want %h", i, got_q[got_rd + i], exp_q[i]); end
    end
    got_rd = got_q.size(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int lat;
    ready_mode = 0;
    send_frame(rand_code(), 0, 0, -1, lat);
    send_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 0);
    rst_n = 0;
    #1;
    checks++; if (ev.ev_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", ev.ev_valid); end
    checks++; if (ev.ev_code !== 8'h00) begin failures++; $display("FAIL midrst_code: got %h want 00", ev.ev_code); end
    checks++; if ({ev.ev_ext, ev.ev_brk} !== 2'b00) begin failures++; $display("FAIL midrst_flags: got %b want 00", {ev.ev_ext, ev.ev_brk}); end
    exp_q.delete();
    m_ext = 0; m_brk = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 7; i++) send_bit(1'($urandom), 0);
    kdata = 1;
    repeat (TO_CYC + 60) @(negedge clk);
    drain();
    checks++; if (got_q.size() - got_rd != 0) begin failures++; $display("FAIL midrst_events: got %0d want 0", got_q.size() - got_rd); end
    checks++; if (ev.ev_valid !== 1'b0) begin failures++; $display("FAIL midrst_idle_valid: got %b want 0", ev.ev_valid); end
    got_rd = got_q.size();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_prefix();
    test_parity();
    test_timeout();
    test_overflow();
    test_glitch();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
